// File: rtl/sb_rx_pkg.sv
// Shared sideband RX/TX constants and the deserializer state type.
package sb_rx_pkg;

    localparam int SB_PKT_W      = 64;
    localparam int SB_GAP_CYCLES = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } sb_rx_state_e;

endpackage

// File: rtl/sb_rx_deserializer_if.sv
// Bus between the SB RX front-end (master) and the deserializer (slave).
interface sb_rx_deserializer_if #(
    parameter int DATA_W = sb_rx_pkg::SB_PKT_W
);

    logic              i_rxcksb_en;
    logic              i_rxdatasb;
    logic [DATA_W-1:0] o_packet;
    logic              o_packet_valid;
    logic              o_deser_done;
    logic              o_err_short;
    logic              o_err_gap;
    logic              o_busy;

    modport master (
        output i_rxcksb_en, i_rxdatasb,
        input  o_packet, o_packet_valid, o_deser_done, o_err_short, o_err_gap, o_busy
    );

    modport slave (
        input  i_rxcksb_en, i_rxdatasb,
        output o_packet, o_packet_valid, o_deser_done, o_err_short, o_err_gap, o_busy
    );

endinterface

// File: rtl/sb_rx_shift_reg.sv
// LSB-first shift register with saturating bit counter; o_last flags the shift
// that captures bit DATA_W-1.
module sb_rx_shift_reg
    import sb_rx_pkg::*;
#(
    parameter int DATA_W = SB_PKT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              shift,
    input  logic              drop,
    input  logic              bit_in,
    output logic [DATA_W-1:0] o_word,
    output logic              o_last
);

    localparam int              CW      = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DATA_W);

    logic [DATA_W-1:0] data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // New bits enter at the MSB, so after DATA_W shifts bit k sits at index k.
    always_comb begin
        o_word = shift ? {bit_in, data_q[DATA_W-1:1]} : data_q;
        o_last = shift && (cnt_q == CNT_MAX - 1'b1);
        data_d = o_word;
        cnt_d  = cnt_q;
        if (start) begin
            data_d = {bit_in, {(DATA_W-1){1'b0}}};
            cnt_d  = CW'(1);
        end else if (drop) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (shift && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sb_rx_deserializer.sv
// Sideband RX deserializer: rebuilds 64-bit bursts and enforces the idle gap.
// Gap checking is enabled by defining SB_RX_GAP_CHECK_EN.
module sb_rx_deserializer
    import sb_rx_pkg::*;
#(
    parameter int DATA_W     = SB_PKT_W,
    parameter int GAP_CYCLES = SB_GAP_CYCLES
) (
    input  logic                 i_pll_clk,
    input  logic                 i_rst,
    sb_rx_deserializer_if.slave  sb_if
);

    sb_rx_state_e      state_q, state_d;
    logic [DATA_W-1:0] packet_q, packet_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              short_q, short_d;
    logic              gerr_q, gerr_d;
    logic              sr_start, sr_shift, sr_drop, sr_last;
    logic [DATA_W-1:0] sr_word;

`ifdef SB_RX_GAP_CHECK_EN
    localparam int            GW      = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES);
    logic [GW-1:0] gap_q, gap_d;
`endif

    sb_rx_shift_reg #(.DATA_W(DATA_W)) u_shift (
        .clk    (i_pll_clk),
        .rst    (i_rst),
        .start  (sr_start),
        .shift  (sr_shift),
        .drop   (sr_drop),
        .bit_in (sb_if.i_rxdatasb),
        .o_word (sr_word),
        .o_last (sr_last)
    );

    always_comb begin
        state_d  = state_q;
        packet_d = packet_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        short_d  = 1'b0;
        gerr_d   = 1'b0;
        sr_start = 1'b0;
        sr_shift = 1'b0;
        sr_drop  = 1'b0;
`ifdef SB_RX_GAP_CHECK_EN
        gap_d    = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (sb_if.i_rxcksb_en) begin
                    sr_start = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (sb_if.i_rxcksb_en) begin
                    sr_shift = 1'b1;
                    if (sr_last) begin
                        done_d = 1'b1;
`ifdef SB_RX_GAP_CHECK_EN
                        state_d = GAP;
                        gap_d   = '0;
`else
                        packet_d = sr_word;
                        valid_d  = 1'b1;
                        state_d  = IDLE;
`endif
                    end
                end else begin
                    short_d = 1'b1;
                    sr_drop = 1'b1;
                    state_d = IDLE;
                end
            end
`ifdef SB_RX_GAP_CHECK_EN
            // A bit arriving on the delivery cycle is a legal start of the next burst.
            GAP: begin
                if (gap_q == GAP_MAX) begin
                    packet_d = sr_word;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                    if (sb_if.i_rxcksb_en) begin
                        sr_start = 1'b1;
                        state_d  = SHIFT;
                    end
                end else if (sb_if.i_rxcksb_en) begin
                    gerr_d   = 1'b1;
                    sr_start = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_pll_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            packet_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            gerr_q   <= 1'b0;
`ifdef SB_RX_GAP_CHECK_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            packet_q <= packet_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            short_q  <= short_d;
            gerr_q   <= gerr_d;
`ifdef SB_RX_GAP_CHECK_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign sb_if.o_packet       = packet_q;
    assign sb_if.o_packet_valid = valid_q;
    assign sb_if.o_deser_done   = done_q;
    assign sb_if.o_err_short    = short_q;
    assign sb_if.o_err_gap      = gerr_q;
    assign sb_if.o_busy         = (state_q != IDLE);

endmodule

// File: doc/sb_rx_deserializer.md
Name: sb_rx_deserializer

Overview:
- Sideband receive-side counterpart of the TX gated-clock serializer.
- Consumes the forwarded sideband bit stream (RXDATASB) plus a per-cycle clock-activity qualifier derived from RXCKSB.
- Reassembles each 64-bit burst LSB-first, checks the 32-cycle idle gap between bursts, and hands complete packets to the SB RX packet decoder.
- Sits between the SB RX analog front-end/synchronizer and the SB RX decoder.

Parameters:
- DATA_W, 64, bits per sideband packet burst.
- GAP_CYCLES, 32, minimum idle (clock-gated) cycles that must follow each burst.

Ports:
- i_pll_clk  input  1  sideband clock (800 MHz), single clock domain.
- i_rst  input  1  synchronous, active-high reset.
- i_rxcksb_en  input  1  high on each cycle in which RXCKSB toggled (bit present).
- i_rxdatasb  input  1  sampled RXDATASB bit, valid only when i_rxcksb_en=1.
- o_packet  output  DATA_W  last completed packet; held until the next completion.
- o_packet_valid  output  1  one-cycle pulse when o_packet is updated.
- o_deser_done  output  1  one-cycle pulse when the DATA_W-th bit is captured.
- o_err_short  output  1  one-cycle pulse when a burst ends before DATA_W bits.
- o_err_gap  output  1  one-cycle pulse when a new burst starts before GAP_CYCLES idle cycles have elapsed.
- o_busy  output  1  high while state != IDLE.

Behaviour:
- Reset (i_rst=1 sampled at posedge): state=IDLE, bit count=0, gap count=0, shift register=0. Outputs: o_packet=0, all pulse outputs=0, o_busy=0. Reset mid-burst discards the partial packet and produces no pulses.
- Bit order: the k-th received bit (k=0..63) lands in o_packet[k].
- Counters: bit counter 7 bits, saturates at DATA_W. Gap counter 6 bits, saturates at GAP_CYCLES. No wrap-around.
- IDLE:
  - i_rxcksb_en=1: capture bit 0, count=1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - i_rxcksb_en=1: capture the bit and increment count. When the captured bit is bit 63, pulse o_deser_done the next cycle and go to GAP with gap count=0.
  - i_rxcksb_en=0 with count<DATA_W: pulse o_err_short the next cycle, discard, go to IDLE.
- GAP:
  - i_rxcksb_en=0: increment gap count.
  - Gap count reaches GAP_CYCLES: load o_packet, pulse o_packet_valid, go to IDLE.
  - Valid latency: o_packet_valid rises the cycle after the 32nd idle cycle is sampled, i.e. 33 cycles after o_deser_done.
  - i_rxcksb_en=1 before GAP_CYCLES: pulse o_err_gap and discard the pending packet. The current bit is captured as bit 0 of a new burst (count=1, SHIFT).
- Simultaneous events:
  - At most one error pulse per cycle.
  - o_packet_valid and o_err_* are mutually exclusive by construction.
- Continuous i_rxcksb_en beyond 64 bits: treated as a gap violation on bit 64. That bit starts the next burst.

Optional Feature:
- Macro: SB_RX_GAP_CHECK_EN.
- Defined: GAP state and o_err_gap behave as above.
- Undefined:
  - No GAP state; o_err_gap tied to 0.
  - o_packet loads and o_packet_valid pulses in the same cycle as o_deser_done, i.e. 1 cycle after the 64th bit.
  - FSM returns to IDLE, and any following active cycle starts a new burst immediately.

Decomposition:
- Shared package sb_rx_pkg holds:
  - SB_PKT_W=64 and SB_GAP_CYCLES=32 (shared with the TX side);
  - typedef enum sb_rx_state_e {IDLE, SHIFT, GAP}.
- One natural sub-module: sb_rx_shift_reg (DATA_W LSB-first shift register with bit counter and done flag). FSM and gap counter stay in the top.

Test Plan:
- Nominal: reset, then 64 active cycles carrying 64'hA5A5_0F0F_1234_5678 LSB-first, then 32 idle cycles. Expect o_deser_done once, o_packet_valid exactly 33 cycles later, and o_packet=64'hA5A5_0F0F_1234_5678.
- Back-to-back: two packets 64'h1 and 64'hFFFF_FFFF_FFFF_FFFF, each followed by exactly 32 idle cycles. Expect two valid pulses with the correct values and no errors.
- Short burst: 40 active cycles then idle. Expect o_err_short one cycle after the first idle cycle, no o_packet_valid, and o_packet unchanged.
- Gap violation: 64 active cycles, 10 idle, then 64 active and 32 idle. Expect o_err_gap on the 11th cycle after the first burst, and only the second packet delivered.
- Reset mid-burst: assert i_rst after 30 bits. Expect all outputs 0 next cycle. A following full burst plus 32 idle cycles is delivered correctly.
- Macro undefined: nominal burst. Expect o_packet_valid coincident with o_deser_done and o_err_gap never asserted under a 5-cycle gap.
